// File: rtl/pl_pkg.sv
// pl_pkg: shared state encoding and ID width for the layer-pipeline sequencer.
package pl_pkg;

    localparam int PL_ID_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT
    } pl_state_t;

endpackage

// File: rtl/pl_id_shadow.sv
// pl_id_shadow: follows each injected proof ID down the comp and sum-check
// chains, one stage per step, so the ID at the chain tail is known on completion.
module pl_id_shadow
    import pl_pkg::*;
#(
    parameter int depth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  shift_i,
    input  logic [PL_ID_BITS-1:0] id_i,
    output logic [PL_ID_BITS-1:0] tail_o
);

    logic [PL_ID_BITS-1:0] shadow_q [depth];

    // Every step moves each ID one stage further along the chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < depth; i++) shadow_q[i] <= '0;
        end else if (shift_i) begin
            shadow_q[0] <= id_i;
            for (int i = 1; i < depth; i++) shadow_q[i] <= shadow_q[i-1];
        end
    end

    assign tail_o = shadow_q[depth-1];

endmodule

// File: rtl/pl_stage_sequencer.sv
// pl_stage_sequencer: accepts proof requests, issues the global step pulse,
// injects the heads of the comp/sum-check enable chains and reports completion
// at the chain tail. A step only advances once every active stage is ready.
module pl_stage_sequencer
    import pl_pkg::*;
#(
    parameter int nlayers = 4,
    parameter int settle  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic                  en_o,
    output logic                  comp_en_head_o,
    output logic                  sumchk_en_head_o,
    output logic [PL_ID_BITS-1:0] id_c_head_o,
    output logic [PL_ID_BITS-1:0] id_p_head_o,
    input  logic [nlayers-1:0]    comp_act_i,
    input  logic [nlayers-1:0]    sumchk_act_i,
    input  logic [nlayers-1:0]    comp_rdy_i,
    input  logic [nlayers-1:0]    sumchk_rdy_i,
    input  logic [PL_ID_BITS-1:0] tail_id_c_i,
    output logic                  busy_o,
    output logic                  done_pulse_o,
    output logic [PL_ID_BITS-1:0] done_id_o
);

    // The ISSUE cycle counts as the first settle cycle, so SETTLE itself
    // covers the remaining settle-1 cycles before WAIT samples ready levels.
    localparam int CntW = (settle > 2) ? $clog2(settle - 1) : 1;
    localparam logic [CntW-1:0] SettleLast = CntW'((settle > 1) ? settle - 2 : 0);

    pl_state_t             state_q;
    logic                  reqReady_q;
    logic                  en_q;
    logic                  compEnHead_q;
    logic                  sumchkEnHead_q;
    logic [PL_ID_BITS-1:0] idCHead_q;
    logic [PL_ID_BITS-1:0] idPHead_q;
    logic [PL_ID_BITS-1:0] idCtr_q;
    logic [PL_ID_BITS-1:0] idCtr_d;
    logic [CntW-1:0]       settleCnt_q;
    logic                  donePulse_q;
    logic [PL_ID_BITS-1:0] doneId_q;

    logic                  handshake;
    logic                  anyAct;
    logic                  stepDue;
    logic                  allReady;
    logic [PL_ID_BITS-1:0] shadowIn;
    logic [PL_ID_BITS-1:0] shadowTail;

    assign handshake = req_valid_i & reqReady_q & (state_q == IDLE);
    assign anyAct    = (|comp_act_i) | (|sumchk_act_i);
    assign stepDue   = handshake | anyAct;
    assign allReady  = &((~comp_act_i | comp_rdy_i) & (~sumchk_act_i | sumchk_rdy_i));
    assign idCtr_d   = idCtr_q + 1'b1;
    assign shadowIn  = compEnHead_q ? idCHead_q : '0;

    pl_id_shadow #(
        .depth (2 * nlayers)
    ) u_shadow (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .shift_i (en_q),
        .id_i    (shadowIn),
        .tail_o  (shadowTail)
    );

    // Sequencer FSM with registered step, head and completion outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            reqReady_q     <= 1'b0;
            en_q           <= 1'b0;
            compEnHead_q   <= 1'b0;
            sumchkEnHead_q <= 1'b0;
            idCHead_q      <= '0;
            idPHead_q      <= '0;
            idCtr_q        <= '0;
            settleCnt_q    <= '0;
            donePulse_q    <= 1'b0;
            doneId_q       <= '0;
        end else begin
            en_q        <= 1'b0;
            donePulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    reqReady_q <= 1'b1;
                    if (stepDue) begin
                        state_q        <= ISSUE;
                        en_q           <= 1'b1;
                        reqReady_q     <= 1'b0;
                        compEnHead_q   <= handshake;
                        sumchkEnHead_q <= comp_act_i[nlayers-1];
                        idPHead_q      <= tail_id_c_i;
                        if (handshake) begin
                            idCHead_q <= idCtr_q;
                            idCtr_q   <= idCtr_d;
                        end
                    end
                end
                ISSUE: begin
                    settleCnt_q <= '0;
                    state_q     <= (settle > 1) ? SETTLE : WAIT;
                end
                SETTLE: begin
                    if (settleCnt_q == SettleLast) begin
                        state_q <= WAIT;
                    end else begin
                        settleCnt_q <= settleCnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (allReady) begin
                        state_q      <= IDLE;
                        reqReady_q   <= 1'b1;
                        compEnHead_q <= 1'b0;
                        donePulse_q  <= sumchk_act_i[nlayers-1];
                        if (sumchk_act_i[nlayers-1]) doneId_q <= shadowTail;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o      = reqReady_q;
    assign en_o             = en_q;
    assign comp_en_head_o   = compEnHead_q;
    assign sumchk_en_head_o = sumchkEnHead_q;
    assign id_c_head_o      = idCHead_q;
    assign id_p_head_o      = idPHead_q;
    assign busy_o           = (state_q != IDLE) | anyAct;
    assign done_pulse_o     = donePulse_q;
    assign done_id_o        = doneId_q;

endmodule

// File: tb/tb_pl_stage_sequencer.sv
// tb_pl_stage_sequencer: drives the sequencer from a model of the layer chain
// and checks it against a proof-level model that tracks each proof's age in steps.
module tb_pl_stage_sequencer;

    localparam int NL     = 4;
    localparam int SETTLE = 2;

    logic          clk;
    logic          rst;
    logic          reqValid;
    logic          reqReady;
    logic          en;
    logic          compEnHead;
    logic          sumchkEnHead;
    logic [31:0]   idCHead;
    logic [31:0]   idPHead;
    logic [NL-1:0] compAct;
    logic [NL-1:0] sumchkAct;
    logic [NL-1:0] compRdy;
    logic [NL-1:0] sumchkRdy;
    logic [31:0]   tailIdC;
    logic          busy;
    logic          donePulse;
    logic [31:0]   doneId;

    pl_stage_sequencer #(
        .nlayers (NL),
        .settle  (SETTLE)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (reqValid),
        .req_ready_o      (reqReady),
        .en_o             (en),
        .comp_en_head_o   (compEnHead),
        .sumchk_en_head_o (sumchkEnHead),
        .id_c_head_o      (idCHead),
        .id_p_head_o      (idPHead),
        .comp_act_i       (compAct),
        .sumchk_act_i     (sumchkAct),
        .comp_rdy_i       (compRdy),
        .sumchk_rdy_i     (sumchkRdy),
        .tail_id_c_i      (tailIdC),
        .busy_o           (busy),
        .done_pulse_o     (donePulse),
        .done_id_o        (doneId)
    );

    int checks = 0;
    int errors = 0;

    // layer chain environment
    logic [NL-1:0] envComp;
    logic [NL-1:0] envSum;
    logic [31:0]   envIdc [NL];
    int            readyMode;
    logic [NL-1:0] manualRdy;

    // proof-level reference model
    logic [31:0] modelCtr;
    logic [31:0] pendId;
    logic [31:0] ids[$];
    int          ages[$];
    bit          reported[$];
    bit          prevHs;
    logic        prevEn;
    int          cycle;
    int          lastEnCycle;
    bit          spacingOn;
    int          enCount;
    int          donesSeen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveEnv();
        compAct   = envComp;
        sumchkAct = envSum;
        tailIdC   = envIdc[NL-1];
        case (readyMode)
            0: begin
                compRdy   = '1;
                sumchkRdy = '1;
            end
            1: begin
                compRdy   = manualRdy;
                sumchkRdy = manualRdy;
            end
            default: begin
                compRdy   = ($urandom_range(0, 2) == 0) ? '1 : NL'($urandom);
                sumchkRdy = ($urandom_range(0, 2) == 0) ? '1 : NL'($urandom);
            end
        endcase
    endtask

    task automatic clearEnv();
        envComp = '0;
        envSum  = '0;
        for (int i = 0; i < NL; i++) envIdc[i] = '0;
    endtask

    // One clock: check the current cycle against the model, then advance.
    task automatic tick();
        logic obsEn, obsValid, obsReady, obsCompHead, obsSumHead, obsRst, obsDone;
        logic [31:0] obsIdC, obsIdP, obsDoneId;
        logic expSum;
        logic [31:0] expIdP;
        int idx;
        bit hs;
        obsEn       = en;
        obsValid    = reqValid;
        obsReady    = reqReady;
        obsCompHead = compEnHead;
        obsSumHead  = sumchkEnHead;
        obsRst      = rst;
        obsDone     = donePulse;
        obsIdC      = idCHead;
        obsIdP      = idPHead;
        obsDoneId   = doneId;
        hs = obsValid && obsReady && !obsRst;
        if (!obsRst) begin
            if (prevHs) begin
                checkOutput("en_after_req", 32'(obsEn), 1);
                checkOutput("comp_head_req", 32'(obsCompHead), 1);
                checkOutput("id_c_head", obsIdC, pendId);
            end
            if (obsDone) begin
                idx = -1;
                for (int i = 0; i < ids.size(); i++)
                    if (ages[i] == 2 * NL && !reported[i]) idx = i;
                if (idx < 0) begin
                    checkOutput("done_spurious", 32'(obsDone), 0);
                end else begin
                    checkOutput("done_id", obsDoneId, ids[idx]);
                    reported[idx] = 1'b1;
                    donesSeen++;
                end
            end
            if (obsEn) begin
                enCount++;
                checkOutput("en_width", 32'(prevEn), 0);
                checkOutput("en_due", 32'(prevHs || ids.size() > 0), 1);
                if (!prevHs) checkOutput("comp_head_drain", 32'(obsCompHead), 0);
                expSum = 1'b0;
                expIdP = '0;
                for (int i = 0; i < ids.size(); i++)
                    if (ages[i] == NL) begin
                        expSum = 1'b1;
                        expIdP = ids[i];
                    end
                checkOutput("sumchk_head", 32'(obsSumHead), 32'(expSum));
                if (expSum) checkOutput("id_p_head", obsIdP, expIdP);
                for (int i = ids.size() - 1; i >= 0; i--) begin
                    if (ages[i] >= 2 * NL) begin
                        checkOutput("done_reported", 32'(reported[i]), 1);
                        ids.delete(i);
                        ages.delete(i);
                        reported.delete(i);
                    end else begin
                        ages[i] = ages[i] + 1;
                    end
                end
                if (prevHs) begin
                    ids.push_back(pendId);
                    ages.push_back(1);
                    reported.push_back(1'b0);
                end
                if (spacingOn && lastEnCycle >= 0)
                    checkOutput("en_spacing", 32'(cycle - lastEnCycle), 32'(2 + SETTLE));
                lastEnCycle = cycle;
            end
            if (hs) begin
                pendId   = modelCtr;
                modelCtr = modelCtr + 1;
            end
        end
        prevEn = obsRst ? 1'b0 : obsEn;
        prevHs = hs;
        @(posedge clk);
        #1;
        cycle++;
        if (obsRst) begin
            clearEnv();
            ids.delete();
            ages.delete();
            reported.delete();
            modelCtr = '0;
        end else if (obsEn) begin
            for (int i = NL - 1; i > 0; i--) begin
                envComp[i] = envComp[i-1];
                envSum[i]  = envSum[i-1];
                envIdc[i]  = envIdc[i-1];
            end
            envComp[0] = obsCompHead;
            envSum[0]  = obsSumHead;
            envIdc[0]  = obsIdC;
        end
        driveEnv();
    endtask

    task automatic applyStimulus(input logic valid, input int cycles);
        reqValid = valid;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic sendRequest(input int budget);
        int n;
        n = 0;
        reqValid = 1'b1;
        do begin
            tick();
            n++;
        end while (!prevHs && n < budget);
        reqValid = 1'b0;
        checkOutput("req_accept", 32'(prevHs), 1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        reqValid  = 1'b0;
        readyMode = 0;
        driveEnv();
        while (!(ids.size() == 0 && busy === 1'b0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_busy", 32'(busy), 0);
        checkOutput("drain_model_empty", 32'(ids.size()), 0);
        checkOutput("drain_req_ready", 32'(reqReady), 1);
        applyStimulus(1'b0, 3);
    endtask

    task automatic checkResetState(input string where);
        checkOutput({where, "_en"}, 32'(en), 0);
        checkOutput({where, "_req_ready"}, 32'(reqReady), 0);
        checkOutput({where, "_comp_head"}, 32'(compEnHead), 0);
        checkOutput({where, "_sumchk_head"}, 32'(sumchkEnHead), 0);
        checkOutput({where, "_id_c_head"}, idCHead, 0);
        checkOutput({where, "_id_p_head"}, idPHead, 0);
        checkOutput({where, "_done_pulse"}, 32'(donePulse), 0);
        checkOutput({where, "_done_id"}, doneId, 0);
        checkOutput({where, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int n;
        int donesBefore;
        rst         = 1'b1;
        reqValid    = 1'b0;
        readyMode   = 0;
        manualRdy   = '1;
        modelCtr    = '0;
        pendId      = '0;
        prevHs      = 1'b0;
        prevEn      = 1'b0;
        cycle       = 0;
        lastEnCycle = -1;
        spacingOn   = 1'b0;
        enCount     = 0;
        donesSeen   = 0;
        clearEnv();
        driveEnv();

        // reset state, then req_ready rises one cycle after reset is released
        tick();
        tick();
        checkResetState("reset");
        rst = 1'b0;
        tick();
        checkOutput("ready_after_reset", 32'(reqReady), 1);

        // single request, full drain, proof 0 completes
        sendRequest(10);
        drain(200);
        checkOutput("first_done_count", 32'(donesSeen), 1);

        // second request gets ID 1
        sendRequest(10);
        drain(200);
        checkOutput("second_done_count", 32'(donesSeen), 2);

        // stale ready levels must not end WAIT
        readyMode = 1;
        manualRdy = '1;
        driveEnv();
        sendRequest(10);
        tick();
        manualRdy = '0;
        driveEnv();
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stale_hold_ready", 32'(reqReady), 0);
            checkOutput("stale_hold_en", 32'(en), 0);
        end
        manualRdy = '1;
        driveEnv();
        n = 0;
        while (reqReady !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        checkOutput("stale_release", 32'(reqReady), 1);
        drain(200);

        // back-to-back requests with immediate ready
        readyMode   = 0;
        driveEnv();
        spacingOn   = 1'b1;
        lastEnCycle = -1;
        enCount     = 0;
        reqValid    = 1'b1;
        n = 0;
        while (enCount < 5 && n < 60) begin
            tick();
            n++;
        end
        checkOutput("b2b_en_count", 32'(enCount >= 5), 1);
        reqValid  = 1'b0;
        spacingOn = 1'b0;
        drain(300);

        // ID counter wrap
        force dut.idCtr_q = 32'hFFFF_FFFF;
        #1;
        release dut.idCtr_q;
        modelCtr = 32'hFFFF_FFFF;
        sendRequest(10);
        sendRequest(20);
        checkOutput("wrap_model_ctr", modelCtr, 32'h1);
        drain(300);

        // randomized requests and ready levels
        readyMode = 2;
        for (int i = 0; i < 400; i++) begin
            reqValid = ($urandom_range(0, 3) == 0);
            tick();
        end
        drain(2000);

        // reset asserted while waiting for ready
        readyMode = 1;
        manualRdy = '0;
        driveEnv();
        sendRequest(10);
        tick();
        tick();
        tick();
        checkOutput("wait_before_reset", 32'(reqReady), 0);
        rst = 1'b1;
        clearEnv();
        driveEnv();
        tick();
        checkResetState("mid_reset");
        rst = 1'b0;
        manualRdy = '1;
        driveEnv();
        donesBefore = donesSeen;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("post_reset_done", 32'(donePulse), 0);
            checkOutput("post_reset_en", 32'(en), 0);
        end
        checkOutput("post_reset_done_count", 32'(donesSeen - donesBefore), 0);

        // counter restarts at 0 after reset
        readyMode = 0;
        driveEnv();
        sendRequest(10);
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pl_stage_sequencer.md
# pl_stage_sequencer

Pipeline sequencer for a chain of pipelined layer tops. It accepts new computation requests, issues the global `en` step pulse, and injects the head bits of the `comp_en`/`sumchk_en` shift chain and the head IDs. It waits until every active stage reports ready before advancing. It sits directly upstream of layer 0 (comp path) and of the first sum-check layer, and reports proof completion at the chain tail.

## Interface
Parameters:
- `nlayers`, 4: number of layer tops in the chain; must be ≥ 1.
- `settle`, 2: cycles after `en` before `*_ready` levels are trusted; must be ≥ 1.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  new computation requested.
- `req_ready`  out  1  request accepted this cycle when both high.
- `en`  out  1  step pulse to all layers; exactly one cycle high.
- `comp_en_head`  out  1  `comp_en_in` of layer 0.
- `sumchk_en_head`  out  1  `sumchk_en_in` of first sum-check layer.
- `id_c_head`  out  32  `id_c_in` of layer 0.
- `id_p_head`  out  32  `id_p_in` of first sum-check layer.
- `comp_act`  in  nlayers  per-layer `comp_en_out`.
- `sumchk_act`  in  nlayers  per-layer `sumchk_en_out`.
- `comp_rdy`  in  nlayers  per-layer `comp_ready` level.
- `sumchk_rdy`  in  nlayers  per-layer `sumchk_ready` level.
- `tail_id_c`  in  32  `id_c_out` of last layer.
- `busy`  out  1  any stage active or step in progress.
- `done_pulse`  out  1  one-cycle pulse when a proof leaves the tail.
- `done_id`  out  32  ID of the completed proof; valid with `done_pulse`.

## Operation
- FSM states: IDLE, ISSUE, SETTLE, WAIT.
- IDLE: `req_ready`=1. A step is due if the request handshake fires, or if any bit of `comp_act`/`sumchk_act` is set. If a step is due, go to ISSUE.
  - A request is accepted only in IDLE.
  - When the handshake fires, latch `comp_en_head`=1 and `id_c_head`=`id_ctr`, then increment `id_ctr`. `id_ctr` is 32-bit and wraps from 0xFFFFFFFF to 0.
  - With no request, `comp_en_head`=0.
- Sum-check head:
  - `sumchk_en_head` = `comp_act[nlayers-1]` sampled on entry to ISSUE.
  - `id_p_head` = `tail_id_c` at the same sample.
- ISSUE: `en`=1 for one cycle. Head outputs are held stable through ISSUE. Next state is SETTLE.
- SETTLE: count `settle` cycles, then go to WAIT.
- WAIT: hold until, for every layer i, (`comp_act[i]`→`comp_rdy[i]`) and (`sumchk_act[i]`→`sumchk_rdy[i]`). Then return to IDLE and clear `comp_en_head`.
- Completion:
  - In the WAIT→IDLE transition, if `sumchk_act[nlayers-1]`=1, pulse `done_pulse` for one cycle.
  - `done_id` is taken from a 2*nlayers-deep ID shadow shift register, advanced on each `en`.
- `busy` = (state≠IDLE) | (|`comp_act`) | (|`sumchk_act`).
- If no request arrives and all act bits are 0, remain in IDLE with no `en`; the pipeline is drained.

## Timing
- Reset: state=IDLE, `en`=0, heads=0, IDs=0, `id_ctr`=0, `done_pulse`=0, `busy`=0, shadow register cleared. `req_ready` is 0 in the reset cycle and 1 in the first cycle after reset.
- Latency from request handshake to `en`: 1 cycle (ISSUE follows IDLE directly).
- Minimum step period: 2+`settle` cycles plus WAIT time.
- A request and drain-driven stepping in the same IDLE cycle merge into one step.
- `req_valid` may drop while `req_ready`=0 without any effect.
- Ready levels are ignored during ISSUE and SETTLE. Stale-high ready from the previous step must not end WAIT early.
- `rst` mid-step: `en` drops in the same cycle `rst` is sampled. No `done_pulse` is emitted, and the in-flight ID is discarded.
- `nlayers`=1: the tail is also the head. The `sumchk_en_head` sample uses `comp_act[0]`.

## Structure
- Shared package `pl_pkg`: `pl_state_t` enum (IDLE, ISSUE, SETTLE, WAIT) and `PL_ID_BITS`=32.
- One natural sub-module: `pl_id_shadow`, an ID shift register of depth 2*nlayers with a tap at the tail. The rest is inline.

## Test plan
- Reset then single request, nlayers=4: `en` one cycle after the handshake; `id_c_head`=0 at `en`; second request gives ID 1.
- Drain without requests: after one request, `en` keeps stepping while act bits are set. `sumchk_en_head`=1 on the step after `comp_act[3]`=1. `done_pulse` with `done_id`=0 follows, then IDLE with `busy`=0.
- Stale ready: hold all `*_rdy`=1 through `en`, then drop at +1. WAIT must not exit until the ready bits are re-raised.
- Back-to-back requests with `req_valid` held high: `en` spacing is exactly 2+`settle` cycles when ready bits are immediate.
- ID wrap: preload `id_ctr`=0xFFFFFFFF by forcing. The next two accepted requests get IDs 0xFFFFFFFF and 0.
- Reset asserted during WAIT: the next cycle is IDLE with all outputs 0. The late ready bits that follow produce no `done_pulse`.
